// File: rtl/wb_riscv_ctrl_pkg.sv
// Shared constants for the Wishbone RISC-V core control block: register map,
// CTRL / MBOX_STAT bit positions and the byte-lane write helper.
package wb_riscv_ctrl_pkg;

  localparam logic [31:0] DEFAULT_CORE_ID = 32'h5448_0001;

  localparam logic [7:0] OFF_ID        = 8'h00;
  localparam logic [7:0] OFF_CTRL      = 8'h04;
  localparam logic [7:0] OFF_IO_OUT    = 8'h08;
  localparam logic [7:0] OFF_IO_OEB    = 8'h0C;
  localparam logic [7:0] OFF_MBOX_DATA = 8'h10;
  localparam logic [7:0] OFF_MBOX_STAT = 8'h14;
  localparam logic [7:0] OFF_SCRATCH   = 8'h18;
  localparam logic [7:0] OFF_IO_HI     = 8'h1C;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_RUN      = 2;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_W        = 4;

  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_COUNT_MSB = 2;
  localparam int STAT_EMPTY     = 3;
  localparam int STAT_FULL      = 4;
  localparam int STAT_OVF       = 5;
  localparam int STAT_UDF       = 6;

  localparam int MBOX_DEPTH  = 4;
  localparam int MBOX_DATA_W = 8;

  // Field order mirrors the MBOX_STAT bit indices above (count in the LSBs).
  typedef struct packed {
    logic       udf;
    logic       ovf;
    logic       full;
    logic       empty;
    logic [2:0] count;
  } mbox_stat_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_riscv_ctrl_if.sv
// Wishbone classic slave bus bundle for the core control block.
interface wb_riscv_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/mbox_fifo.sv
// Small synchronous FIFO used as the core-to-host mailbox. Push is refused
// when full and pop when empty; DEPTH must be a power of two.
module mbox_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [DATA_W-1:0]                wdata,
  input  logic                             pop,
  output logic [DATA_W-1:0]                rdata,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_riscv_ctrl.sv
// Wishbone register window controlling a RISC-V core: ID, CTRL, pad monitor
// readback, a 4-entry core-to-host mailbox with sticky error flags, scratch.
module wb_riscv_ctrl
  import wb_riscv_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] CORE_ID   = DEFAULT_CORE_ID
) (
  input  logic           wb_clk_i,
  input  logic           rst_n,
  wb_riscv_ctrl_if.slave wb,
  output logic [1:0]     custom_settings,
  output logic           core_rst_n,
  input  logic [32:0]    io_out_mon,
  input  logic [33:0]    io_oeb_mon,
  input  logic [7:0]     mbox_wdata,
  input  logic           mbox_wvalid,
  output logic           mbox_wready,
  output logic [2:0]     user_irq
);
  localparam int CNT_W = $clog2(MBOX_DEPTH + 1);

  logic              hit, access, wr_en, rd_en;
  logic [7:0]        reg_off;
  logic              ack_q;
  logic [31:0]       dat_q, rd_data;
  logic [CTRL_W-1:0] ctrl_q;
  logic [31:0]       scratch_q;
  logic              ovf_q, udf_q, irq_q;
  logic [32:0]       io_out_p0, io_out_p1;
  logic [33:0]       io_oeb_p0, io_oeb_p1;
  logic              mbox_rd, stat_wr;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  mbox_stat_t        stat;
  logic              unused_adr_bits;

  // An access is accepted only when ack is low, so each transfer yields a
  // single-cycle ack and back-to-back transfers take two cycles.
  assign hit     = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign access  = hit & ~ack_q;
  assign wr_en   = access & wb.wbs_we_i;
  assign rd_en   = access & ~wb.wbs_we_i;
  assign reg_off = {wb.wbs_adr_i[7:2], 2'b00};
  assign unused_adr_bits = ^wb.wbs_adr_i[1:0];

  assign mbox_rd  = rd_en & (reg_off == OFF_MBOX_DATA);
  assign fifo_pop = mbox_rd & ~fifo_empty;
  assign stat_wr  = wr_en & (reg_off == OFF_MBOX_STAT) & wb.wbs_sel_i[0];

  mbox_fifo #(
    .DATA_W (MBOX_DATA_W),
    .DEPTH  (MBOX_DEPTH)
  ) u_mbox (
    .clk   (wb_clk_i),
    .rst_n (rst_n),
    .push  (mbox_wvalid),
    .wdata (mbox_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign mbox_wready = ~fifo_full;

  always_comb begin
    stat       = '0;
    stat.count = fifo_count;
    stat.empty = fifo_empty;
    stat.full  = fifo_full;
    stat.ovf   = ovf_q;
    stat.udf   = udf_q;
  end

  always_comb begin
    rd_data = '0;
    case (reg_off)
      OFF_ID:        rd_data = CORE_ID;
      OFF_CTRL:      rd_data = {{(32-CTRL_W){1'b0}}, ctrl_q};
      OFF_IO_OUT:    rd_data = io_out_p1[31:0];
      OFF_IO_OEB:    rd_data = io_oeb_p1[31:0];
      OFF_MBOX_DATA: rd_data = fifo_empty ? 32'h0 : {24'h0, fifo_head};
      OFF_MBOX_STAT: rd_data = {25'h0, stat};
      OFF_SCRATCH:   rd_data = scratch_q;
      OFF_IO_HI:     rd_data = {29'h0, io_out_p1[32], io_oeb_p1[33:32]};
      default:       rd_data = '0;
    endcase
  end

  // Monitor synchroniser stage p0 -> p1
  always_ff @(posedge wb_clk_i) begin
    io_out_p0 <= io_out_mon;
    io_oeb_p0 <= io_oeb_mon;
    io_out_p1 <= io_out_p0;
    io_oeb_p1 <= io_oeb_p0;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      ctrl_q    <= '0;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ack_q <= access;
      dat_q <= rd_en ? rd_data : 32'h0;
      if (wr_en && reg_off == OFF_CTRL && wb.wbs_sel_i[0])
        ctrl_q <= wb.wbs_dat_i[CTRL_W-1:0];
      if (wr_en && reg_off == OFF_SCRATCH)
        scratch_q <= merge_bytes(scratch_q, wb.wbs_dat_i, wb.wbs_sel_i);
      // Setting a sticky flag wins over a same-cycle clear.
      if (mbox_wvalid && fifo_full)                 ovf_q <= 1'b1;
      else if (stat_wr && wb.wbs_dat_i[STAT_OVF])   ovf_q <= 1'b0;
      if (mbox_rd && fifo_empty)                    udf_q <= 1'b1;
      else if (stat_wr && wb.wbs_dat_i[STAT_UDF])   udf_q <= 1'b0;
      irq_q <= ctrl_q[CTRL_IRQ_EN] & ~fifo_empty;
    end
  end

  assign wb.wbs_ack_o    = ack_q;
  assign wb.wbs_dat_o    = dat_q;
  assign custom_settings = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign core_rst_n      = ctrl_q[CTRL_RUN];
  assign user_irq        = {2'b00, irq_q};
endmodule
